// File: rtl/pwm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pwm_pkg
// Brief   : Shared constants, capture-state encoding and width decode helper
//           for the servo PWM capture block.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package pwm_pkg;

   // Timebase of the capture clock: 255 ticks per millisecond.
   localparam int          TICKS_PER_MS  = 255;
   localparam int          FRAME_TICKS   = 5100;
   localparam logic [7:0]  NEUTRAL_WIDTH = 8'd127;

   typedef enum logic [1:0] {
      ARM  = 2'd0,   // waiting for a genuine low sample
      LOW  = 2'd1,   // waiting for a rising edge
      HIGH = 2'd2    // counting high ticks
   } capture_state_t;

   // Map a high-time count to an 8-bit width, clamped to [0, 255].
   function automatic logic [7:0] clamp_width(input logic [9:0]  count,
                                              input logic [10:0] offset);
      logic signed [10:0] diff;
      diff = $signed({1'b0, count}) - $signed(offset);
      if (diff < 11'sd0)
         return 8'd0;
      else if (diff > 11'sd255)
         return 8'd255;
      else
         return diff[7:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_input_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pwm_input_sync
// Brief   : Two-flop synchronizer for the raw PWM input with rising/falling
//           edge detection and a "sample is genuine" qualifier.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module pwm_input_sync (
   input  logic clk_255kHz,
   input  logic reset,
   input  logic pwm_in,
   output logic s,
   output logic rise,
   output logic fall,
   output logic ready
);

   logic       meta;
   logic       p;
   logic [1:0] fill;

   // Synchronizer chain plus one-cycle delay of the synchronized sample.
   // fill tracks how far real input data has propagated since reset, so the
   // reset-forced zeros in the chain are never mistaken for a low input.
   always_ff @(posedge clk_255kHz) begin
      if (reset) begin
         meta <= 1'b0;
         s    <= 1'b0;
         p    <= 1'b0;
         fill <= 2'b00;
      end else begin
         meta <= pwm_in;
         s    <= meta;
         p    <= s;
         fill <= {fill[0], 1'b1};
      end
   end

   assign rise  =  s & ~p;
   assign fall  = ~s &  p;
   assign ready = fill[1];

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : pwm_capture
// Brief   : Measures servo-style PWM high time, decodes it into an 8-bit
//           width, flags out-of-range pulses and reports loss of signal.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int         MIN_HIGH = 200,
   parameter int         MAX_HIGH = 600,
   parameter int         OFFSET   = 255,
   parameter int         TIMEOUT  = 15300,
   parameter logic [7:0] FAILSAFE = 8'd127
) (
   input  logic       clk_255kHz,
   input  logic       reset,
   input  logic       pwm_in,
   output logic [7:0] width,
   output logic       width_valid,
   output logic       pulse_error,
   output logic       signal_lost
);

   localparam logic [9:0]  MIN_COUNT   = 10'(MIN_HIGH);
   localparam logic [9:0]  MAX_COUNT   = 10'(MAX_HIGH);
   localparam logic [10:0] OFFSET_W    = 11'(OFFSET);
   localparam logic [13:0] TIMEOUT_CNT = 14'(TIMEOUT);
   localparam logic [9:0]  COUNT_SAT   = 10'h3FF;

   logic           s;
   logic           rise;
   logic           fall;
   logic           ready;
   capture_state_t state;
   logic [9:0]     high_count;
   logic [13:0]    timeout_count;
   logic           pulse_end;
   logic           in_range;
   logic           accept;
   logic           expire;

   pwm_input_sync u_sync (
      .clk_255kHz (clk_255kHz),
      .reset      (reset),
      .pwm_in     (pwm_in),
      .s          (s),
      .rise       (rise),
      .fall       (fall),
      .ready      (ready)
   );

   assign pulse_end = (state == HIGH) && fall;
   assign in_range  = (high_count >= MIN_COUNT) && (high_count <= MAX_COUNT);
   assign accept    = pulse_end && in_range;
   // An accepted pulse on the expiry edge takes priority over the failsafe.
   assign expire    = !accept && (timeout_count == TIMEOUT_CNT - 14'd1);

   // Capture FSM and saturating high-time counter.
   always_ff @(posedge clk_255kHz) begin
      if (reset) begin
         state      <= ARM;
         high_count <= 10'd0;
      end else begin
         case (state)
            ARM: begin
               if (ready && !s)
                  state <= LOW;
            end
            LOW: begin
               if (rise) begin
                  state      <= HIGH;
                  high_count <= 10'd1;
               end
            end
            HIGH: begin
               if (fall)
                  state <= LOW;
               else if (s && (high_count != COUNT_SAT))
                  high_count <= high_count + 10'd1;
            end
            default: state <= ARM;
         endcase
      end
   end

   // Result registers, strobes and loss-of-signal timeout.
   always_ff @(posedge clk_255kHz) begin
      if (reset) begin
         width         <= FAILSAFE;
         width_valid   <= 1'b0;
         pulse_error   <= 1'b0;
         signal_lost   <= 1'b1;
         timeout_count <= 14'd0;
      end else begin
         width_valid <= accept;
         pulse_error <= pulse_end && !in_range;

         if (accept)
            timeout_count <= 14'd0;
         else if (timeout_count != TIMEOUT_CNT)
            timeout_count <= timeout_count + 14'd1;

         if (accept) begin
            width       <= clamp_width(high_count, OFFSET_W);
            signal_lost <= 1'b0;
         end else if (expire) begin
            width       <= FAILSAFE;
            signal_lost <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameters SHALL be: MIN_HIGH, default 200, shortest accepted high time in ticks.
REQ-002 Parameters SHALL be: MAX_HIGH, default 600, longest accepted high time in ticks.
REQ-003 Parameters SHALL be: OFFSET, default 255, high ticks that map to width 0 (1 ms).
REQ-004 Parameters SHALL be: TIMEOUT, default 15300, ticks without an accepted pulse (3 frames) before failsafe.
REQ-005 Parameters SHALL be: FAILSAFE, default 8'd127, width reported when the signal is lost.
REQ-006 clk_255kHz  input  1  block clock; reset is reset, synchronous, active-high; clock is clk_255kHz.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 pwm_in  input  1  asynchronous servo-style pulse input (1–2 ms high, ~20 ms frame).
REQ-009 width  output  8  decoded pulse width: 0 = 1 ms, 255 = 2 ms.
REQ-010 width_valid  output  1  one-cycle strobe on each accepted pulse.
REQ-011 pulse_error  output  1  one-cycle strobe on each rejected pulse.
REQ-012 signal_lost  output  1  high while no accepted pulse has arrived within TIMEOUT ticks.

Function
REQ-013 pwm_in SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized sample s and its 1-cycle delay p.
REQ-014 Rising edge = s&~p; falling edge = ~s&p.
REQ-015 FSM states SHALL be ARM (wait for s=0), LOW (wait for rising edge), HIGH (counting).
REQ-016 Transitions: ARM->LOW when s=0; LOW->HIGH on rising edge; HIGH->LOW on falling edge.
REQ-017 The high counter SHALL be 10 bits, set to 1 on the rising-edge cycle, increment each HIGH cycle with s=1, and saturate at 1023; an N-tick pulse yields count N.
REQ-018 On the falling-edge cycle, count in [MIN_HIGH, MAX_HIGH] SHALL be accepted; any other value SHALL be rejected.
REQ-019 Accepted: width <= clamp(count-OFFSET, 0, 255), using 11-bit signed arithmetic; count<OFFSET gives 0, count>OFFSET+255 gives 255.
REQ-020 width, width_valid and pulse_error SHALL register on the clock after falling-edge detection, i.e. 3 clk_255kHz edges after the first edge sampling raw pwm_in low.
REQ-021 Rejected: width unchanged, pulse_error=1 for one cycle, width_valid=0.
REQ-022 The timeout counter SHALL be 14 bits, cleared on every accepted pulse, increment otherwise, and saturate at TIMEOUT.
REQ-023 When the timeout counter reaches TIMEOUT: signal_lost=1 and width <= FAILSAFE on the same edge.
REQ-024 signal_lost SHALL clear on the same edge width_valid asserts.
REQ-025 A stuck-high input SHALL give no strobe until a falling edge; the saturated count is then rejected, and the timeout runs meanwhile.
REQ-026 If an accepted pulse and timeout expiry coincide, the accepted pulse SHALL win: width = decoded value and signal_lost=0.

Reset
REQ-027 During reset: width=FAILSAFE, width_valid=0, pulse_error=0, signal_lost=1, state=ARM, both counters 0, synchronizer flops 0.
REQ-028 Reset asserted mid-pulse SHALL discard the partial measurement.
REQ-029 After release, a pulse already high SHALL NOT be measured (ARM requires a low sample first).

Structure
REQ-030 Shared package pwm_pkg SHALL hold TICKS_PER_MS=255, FRAME_TICKS=5100, NEUTRAL_WIDTH=8'd127 and the capture-state enum (ARM, LOW, HIGH).
REQ-031 One sub-module, pwm_input_sync, SHALL implement the 2-flop synchronizer plus rise/fall detect; counters, FSM and output registers SHALL stay in pwm_capture.

Verification
REQ-032 After reset with pwm_in low, pulses of 255, 383 and 510 ticks -> width 0, 128, 255 with one width_valid strobe each, and signal_lost 1->0 on the first pulse.
REQ-033 Pulses of 230 and 540 ticks -> width 0 and 255 (clamped); 150 and 700 ticks -> pulse_error strobe, width unchanged, no width_valid.
REQ-034 Valid 400-tick pulse, then pwm_in held low for 15300 ticks -> signal_lost=1 and width=127 exactly at expiry; next 300-tick pulse -> width=45, signal_lost=0.
REQ-035 Reset asserted 100 ticks into a pulse and released while pwm_in is still high -> that pulse yields no strobe; next 355-tick pulse -> width=100.
REQ-036 Loopback from the team PWM generator with width 200 over 5 frames -> width=200 every 5100 ticks, with no pulse_error and no signal_lost.
REQ-037 Strobe timing check: width_valid SHALL occur exactly 3 clocks after raw pwm_in falls.
